bus_fabric_ws: RTL and testbench

Parametrised successor to the single-master address decoder. It maps one CPU data port onto NUM_SLAVES address windows. Each window has its own base, size and fixed wait-state count. Unlike a purely combinational decode, every access is a registered transaction: a request/ready handshake, registered read data and an error response for unmapped or illegal accesses. The block sits between the core's data-memory port and the RAM, screen and button peripherals.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/bus_addr_decode.sv | 39 +++
 rtl/bus_fabric_ws.sv | 178 +++++++++++++++++
 tb/tb_bus_fabric_ws.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types, widths and default address map for the bus fabric.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } bus_state_e;

  localparam int WAIT_W = 4;

  localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
  localparam logic [31:0] RAM_SIZE    = 32'd1024;
  localparam logic [31:0] SCREEN_BASE = 32'h0000_0400;
  localparam logic [31:0] SCREEN_SIZE = 32'd64;
  localparam logic [31:0] BUTTON_BASE = 32'h0000_0800;
  localparam logic [31:0] BUTTON_SIZE = 32'd4;

  // Index width for n slaves; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational priority address decoder: address -> hit, slave index, window offset.
module bus_addr_decode
  import bus_pkg::*;
#(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_SIZE   = '1,
  parameter int                           IDX_W      = idx_w(NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic              hit,
  output logic [IDX_W-1:0]  idx,
  output logic [ADDR_W-1:0] offset
);

  logic [NUM_SLAVES-1:0] win_hit_s;

  // One extra bit keeps a window that ends exactly at 2^ADDR_W from wrapping.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_win
    logic [ADDR_W:0] lo_s;
    logic [ADDR_W:0] hi_s;
    assign lo_s         = {1'b0, SLV_BASE[g*ADDR_W +: ADDR_W]};
    assign hi_s         = lo_s + {1'b0, SLV_SIZE[g*ADDR_W +: ADDR_W]};
    assign win_hit_s[g] = ({1'b0, addr} >= lo_s) && ({1'b0, addr} < hi_s);
  end

  // Priority select: walk downwards so the lowest matching index is applied last.
  always_comb begin
    hit    = |win_hit_s;
    idx    = '0;
    offset = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      idx    = win_hit_s[i] ? IDX_W'(i) : idx;
      offset = win_hit_s[i] ? (addr - SLV_BASE[i*ADDR_W +: ADDR_W]) : offset;
    end
  end

endmodule

// File: rtl/bus_fabric_ws.sv
// Single-master bus fabric with per-window wait states and error responses.
// Optional sticky error capture is enabled with `define BUS_ERR_LATCH_EN.
module bus_fabric_ws
  import bus_pkg::*;
#(
  parameter int                           NUM_SLAVES = 4,
  parameter int                           ADDR_W     = 32,
  parameter int                           DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE   = {32'h0000_0C00, BUTTON_BASE, SCREEN_BASE, RAM_BASE},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_SIZE   = {32'd16, BUTTON_SIZE, SCREEN_SIZE, RAM_SIZE},
  parameter logic [NUM_SLAVES*WAIT_W-1:0] SLV_WAIT   = {4'd3, 4'd0, 4'd1, 4'd0}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic                         cpu_ren,
  input  logic                         cpu_wen,
  input  logic [DATA_W-1:0]            cpu_wdata,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic [NUM_SLAVES-1:0]        slv_ren,
  output logic [NUM_SLAVES-1:0]        slv_wen,
  output logic [ADDR_W-1:0]            slv_addr,
  output logic [DATA_W-1:0]            slv_wdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata,
  output logic                         err_valid,
  output logic [ADDR_W-1:0]            err_addr,
  input  logic                         err_clr
);

  localparam int IDX_W = idx_w(NUM_SLAVES);

  bus_state_e            state_r, state_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic [WAIT_W-1:0]     wait_r, wait_s;
  logic                  write_r, write_s;
  logic                  dec_hit_s;
  logic [IDX_W-1:0]      dec_idx_s;
  logic [ADDR_W-1:0]     dec_offset_s;
  logic [NUM_SLAVES-1:0] dec_sel_s, cur_sel_s;
  logic [NUM_SLAVES-1:0] ren_s, wen_s;
  logic [ADDR_W-1:0]     slv_addr_s;
  logic [DATA_W-1:0]     slv_wdata_s, rdata_s;
  logic                  ready_s, err_s, err_hit_s;

  bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_SIZE   (SLV_SIZE),
    .IDX_W      (IDX_W)
  ) u_decode (
    .addr   (cpu_addr),
    .hit    (dec_hit_s),
    .idx    (dec_idx_s),
    .offset (dec_offset_s)
  );

  assign dec_sel_s = NUM_SLAVES'(1'b1) << dec_idx_s;
  assign cur_sel_s = NUM_SLAVES'(1'b1) << idx_r;

  // Next-state and next-output logic; strobes are computed for the following cycle.
  always_comb begin
    state_s     = state_r;
    idx_s       = idx_r;
    wait_s      = wait_r;
    write_s     = write_r;
    slv_addr_s  = slv_addr;
    slv_wdata_s = slv_wdata;
    rdata_s     = cpu_rdata;
    ren_s       = '0;
    wen_s       = '0;
    ready_s     = 1'b0;
    err_s       = 1'b0;
    err_hit_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if ((cpu_ren ^ cpu_wen) && dec_hit_s) begin
          state_s     = ACCESS;
          idx_s       = dec_idx_s;
          wait_s      = SLV_WAIT[dec_idx_s*WAIT_W +: WAIT_W];
          write_s     = cpu_wen;
          slv_addr_s  = dec_offset_s;
          slv_wdata_s = cpu_wdata;
          ren_s       = cpu_ren ? dec_sel_s : '0;
          wen_s       = cpu_wen ? dec_sel_s : '0;
        end else if (cpu_ren || cpu_wen) begin
          state_s   = DONE;
          ready_s   = 1'b1;
          err_s     = 1'b1;
          rdata_s   = '0;
          err_hit_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (wait_r != {WAIT_W{1'b0}}) begin
          wait_s = wait_r - WAIT_W'(1'b1);
          ren_s  = write_r ? '0 : cur_sel_s;
          wen_s  = write_r ? cur_sel_s : '0;
        end else begin
          state_s = DONE;
          ready_s = 1'b1;
          rdata_s = write_r ? '0 : slv_rdata[idx_r*DATA_W +: DATA_W];
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latched transaction context and registered master/slave outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_r     <= '0;
      wait_r    <= '0;
      write_r   <= 1'b0;
      cpu_rdata <= '0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      slv_ren   <= '0;
      slv_wen   <= '0;
      slv_addr  <= '0;
      slv_wdata <= '0;
    end else begin
      idx_r     <= idx_s;
      wait_r    <= wait_s;
      write_r   <= write_s;
      cpu_rdata <= rdata_s;
      cpu_ready <= ready_s;
      cpu_err   <= err_s;
      slv_ren   <= ren_s;
      slv_wen   <= wen_s;
      slv_addr  <= slv_addr_s;
      slv_wdata <= slv_wdata_s;
    end
  end

`ifdef BUS_ERR_LATCH_EN
  // Sticky first-error capture; a new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else if (err_hit_s && (!err_valid || err_clr)) begin
      err_valid <= 1'b1;
      err_addr  <= cpu_addr;
    end else if (err_clr) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_valid <= err_valid;
      err_addr  <= err_addr;
    end
  end
`else
  logic unused_err_s;
  assign unused_err_s = err_clr ^ err_hit_s;
  assign err_valid    = 1'b0;
  assign err_addr     = '0;
`endif

endmodule

// File: tb/tb_bus_fabric_ws.sv
// Directed self-checking bench for bus_fabric_ws (default address map).
module tb_bus_fabric_ws;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  cpu_addr;
  logic         cpu_ren;
  logic         cpu_wen;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         cpu_ready;
  logic         cpu_err;
  logic [3:0]   slv_ren;
  logic [3:0]   slv_wen;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [127:0] slv_rdata;
  logic         err_valid;
  logic [31:0]  err_addr;
  logic         err_clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_fabric_ws dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_ren   (cpu_ren),
    .cpu_wen   (cpu_wen),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .slv_ren   (slv_ren),
    .slv_wen   (slv_wen),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .err_valid (err_valid),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  // Inputs are changed and outputs sampled on the falling edge.
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", cpu_ready); end
    checks++; if (cpu_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", cpu_err); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", cpu_rdata); end
    checks++; if ({slv_ren, slv_wen} !== 8'h00) begin errors++; $display("FAIL reset_strobes: got %h expected 00", {slv_ren, slv_wen}); end
    checks++; if (slv_addr !== 32'h0 || slv_wdata !== 32'h0) begin errors++; $display("FAIL reset_slv: got addr %h wdata %h expected 0/0", slv_addr, slv_wdata); end
    checks++; if (err_valid !== 1'b0 || err_addr !== 32'h0) begin errors++; $display("FAIL reset_errlatch: got %b/%h expected 0/0", err_valid, err_addr); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b0 || slv_ren !== 4'h0) begin errors++; $display("FAIL idle_quiet: got ready %b ren %h expected 0/0", cpu_ready, slv_ren); end
  endtask

  task automatic test_read_ram();
    cpu_addr = 32'h0000_0010; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (slv_ren !== 4'b0001 || slv_wen !== 4'b0000) begin errors++; $display("FAIL rd_ram_strobe: got ren %b wen %b expected 0001/0000", slv_ren, slv_wen); end
    checks++; if (slv_addr !== 32'h10) begin errors++; $display("FAIL rd_ram_offset: got %h expected 00000010", slv_addr); end
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL rd_ram_early: got ready %b expected 0", cpu_ready); end
    @(negedge clk);
    checks++; if (slv_ren !== 4'b0000) begin errors++; $display("FAIL rd_ram_strobe_end: got %b expected 0000", slv_ren); end
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL rd_ram_ready: got ready %b err %b expected 1/0", cpu_ready, cpu_err); end
    checks++; if (cpu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_ram_data: got %h expected deadbeef", cpu_rdata); end
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b0 || slv_ren !== 4'b0000) begin errors++; $display("FAIL rd_ram_pulse: got ready %b ren %b expected 0/0000", cpu_ready, slv_ren); end
    cpu_ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_screen();
    cpu_addr = 32'h0000_0404; cpu_wen = 1'b1; cpu_wdata = 32'h0000_0055;
    @(negedge clk);
    checks++; if (slv_wen !== 4'b0010 || slv_ren !== 4'b0000) begin errors++; $display("FAIL wr_scr_strobe1: got wen %b ren %b expected 0010/0000", slv_wen, slv_ren); end
    checks++; if (slv_addr !== 32'h4 || slv_wdata !== 32'h55) begin errors++; $display("FAIL wr_scr_latch: got addr %h wdata %h expected 4/55", slv_addr, slv_wdata); end
    cpu_addr = 32'h0000_0010; cpu_wdata = 32'h0000_00AA;
    @(negedge clk);
    checks++; if (slv_wen !== 4'b0010 || cpu_ready !== 1'b0) begin errors++; $display("FAIL wr_scr_strobe2: got wen %b ready %b expected 0010/0", slv_wen, cpu_ready); end
    checks++; if (slv_addr !== 32'h4 || slv_wdata !== 32'h55) begin errors++; $display("FAIL wr_scr_hold: got addr %h wdata %h expected 4/55", slv_addr, slv_wdata); end
    @(negedge clk);
    checks++; if (slv_wen !== 4'b0000 || cpu_ready !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL wr_scr_done: got wen %b ready %b err %b expected 0000/1/0", slv_wen, cpu_ready, cpu_err); end
    checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL wr_scr_rdata: got %h expected 0", cpu_rdata); end
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b0 || slv_wen !== 4'b0000) begin errors++; $display("FAIL wr_scr_pulse: got ready %b wen %b expected 0/0000", cpu_ready, slv_wen); end
    cpu_wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_error_responses();
    cpu_addr = 32'h0000_1000; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b1) begin errors++; $display("FAIL unmapped_resp: got ready %b err %b expected 1/1", cpu_ready, cpu_err); end
    checks++; if (cpu_rdata !== 32'h0 || slv_ren !== 4'b0000) begin errors++; $display("FAIL unmapped_quiet: got rdata %h ren %b expected 0/0000", cpu_rdata, slv_ren); end
    cpu_ren = 1'b0;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b0 || cpu_err !== 1'b0) begin errors++; $display("FAIL unmapped_pulse: got ready %b err %b expected 0/0", cpu_ready, cpu_err); end
    cpu_addr = 32'h0000_0000; cpu_ren = 1'b1; cpu_wen = 1'b1;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b1) begin errors++; $display("FAIL both_resp: got ready %b err %b expected 1/1", cpu_ready, cpu_err); end
    checks++; if ({slv_ren, slv_wen} !== 8'h00) begin errors++; $display("FAIL both_strobe: got %h expected 00", {slv_ren, slv_wen}); end
    cpu_ren = 1'b0; cpu_wen = 1'b0;
    @(negedge clk);
    cpu_addr = 32'h0000_0804; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (cpu_err !== 1'b1 || slv_ren !== 4'b0000) begin errors++; $display("FAIL button_end_err: got err %b ren %b expected 1/0000", cpu_err, slv_ren); end
    cpu_ren = 1'b0;
    @(negedge clk);
    cpu_addr = 32'h0000_043F; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (slv_ren !== 4'b0010 || slv_addr !== 32'h3F) begin errors++; $display("FAIL screen_last: got ren %b addr %h expected 0010/3f", slv_ren, slv_addr); end
    repeat (2) @(negedge clk);
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b0 || cpu_rdata !== 32'h1111_1111) begin errors++; $display("FAIL screen_last_rd: got ready %b err %b data %h expected 1/0/11111111", cpu_ready, cpu_err, cpu_rdata); end
    cpu_ren = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    cpu_addr = 32'h0000_0800; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (slv_ren !== 4'b0100 || slv_addr !== 32'h0) begin errors++; $display("FAIL b2b_first_strobe: got ren %b addr %h expected 0100/0", slv_ren, slv_addr); end
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1 || cpu_rdata !== 32'h2222_2222) begin errors++; $display("FAIL b2b_first_done: got ready %b data %h expected 1/22222222", cpu_ready, cpu_rdata); end
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b0 || slv_ren !== 4'b0000) begin errors++; $display("FAIL b2b_no_resample: got ready %b ren %b expected 0/0000", cpu_ready, slv_ren); end
    cpu_addr = 32'h0000_0803;
    @(negedge clk);
    checks++; if (slv_ren !== 4'b0100 || slv_addr !== 32'h3) begin errors++; $display("FAIL b2b_second_strobe: got ren %b addr %h expected 0100/3", slv_ren, slv_addr); end
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b1 || cpu_err !== 1'b0) begin errors++; $display("FAIL b2b_second_done: got ready %b err %b expected 1/0", cpu_ready, cpu_err); end
    cpu_ren = 1'b0;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL b2b_end: got ready %b expected 0", cpu_ready); end
  endtask

  task automatic test_reset_mid_access();
    cpu_addr = 32'h0000_0C04; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (slv_ren !== 4'b1000 || slv_addr !== 32'h4) begin errors++; $display("FAIL mid_strobe: got ren %b addr %h expected 1000/4", slv_ren, slv_addr); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (slv_ren !== 4'b0000 || cpu_ready !== 1'b0) begin errors++; $display("FAIL mid_abort: got ren %b ready %b expected 0000/0", slv_ren, cpu_ready); end
    rst_n = 1'b1; cpu_ren = 1'b0;
    @(negedge clk);
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL mid_no_ready: got %b expected 0", cpu_ready); end
    cpu_addr = 32'h0000_0C00; cpu_ren = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (slv_ren !== 4'b1000 || cpu_ready !== 1'b0) begin errors++; $display("FAIL w3_last_strobe: got ren %b ready %b expected 1000/0", slv_ren, cpu_ready); end
    @(negedge clk);
    checks++; if (slv_ren !== 4'b0000 || cpu_ready !== 1'b1 || cpu_rdata !== 32'h3333_3333) begin errors++; $display("FAIL w3_done: got ren %b ready %b data %h expected 0000/1/33333333", slv_ren, cpu_ready, cpu_rdata); end
    cpu_ren = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_err_latch();
`ifdef BUS_ERR_LATCH_EN
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL latch_start: got %b expected 0", err_valid); end
    cpu_addr = 32'h0000_1000; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (err_valid !== 1'b1 || err_addr !== 32'h1000) begin errors++; $display("FAIL latch_first: got %b/%h expected 1/1000", err_valid, err_addr); end
    @(negedge clk);
    cpu_addr = 32'h0000_2000;
    @(negedge clk);
    checks++; if (cpu_err !== 1'b1 || err_addr !== 32'h1000) begin errors++; $display("FAIL latch_keep: got err %b addr %h expected 1/1000", cpu_err, err_addr); end
    cpu_ren = 1'b0;
    @(negedge clk);
    cpu_addr = 32'h0000_3000; cpu_ren = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    checks++; if (err_valid !== 1'b1 || err_addr !== 32'h3000) begin errors++; $display("FAIL latch_clr_race: got %b/%h expected 1/3000", err_valid, err_addr); end
    cpu_ren = 1'b0;
    @(negedge clk);
    checks++; if (err_valid !== 1'b0 || err_addr !== 32'h0) begin errors++; $display("FAIL latch_clear: got %b/%h expected 0/0", err_valid, err_addr); end
    err_clr = 1'b0;
    @(negedge clk);
`else
    cpu_addr = 32'h0000_1000; cpu_ren = 1'b1;
    @(negedge clk);
    checks++; if (cpu_err !== 1'b1 || err_valid !== 1'b0 || err_addr !== 32'h0) begin errors++; $display("FAIL latch_disabled: got err %b valid %b addr %h expected 1/0/0", cpu_err, err_valid, err_addr); end
    cpu_ren = 1'b0;
    @(negedge clk);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    cpu_addr  = 32'h0;
    cpu_ren   = 1'b0;
    cpu_wen   = 1'b0;
    cpu_wdata = 32'h0;
    err_clr   = 1'b0;
    slv_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
    test_reset();
    test_read_ram();
    test_write_screen();
    test_error_responses();
    test_back_to_back();
    test_reset_mid_access();
    test_err_latch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
